ram_arb2: RTL

RAM_ARB2 -- requirements
Module: ram_arb2

---
 rtl/veerwolf_pkg.sv | 11 +
 rtl/rr_arb2.sv | 39 +++
 rtl/ram_arb2.sv | 115 +++++++++++
 3 files changed

// File: rtl/veerwolf_pkg.sv
// Shared definitions for the two-port RAM arbiter.
package veerwolf_pkg;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } arb_state_e;

  localparam int unsigned WordBytes = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, pointer moves on completion.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    // A grant is only given to an active request, so every grant completes a transfer.
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_arb2.sv
// Two-port arbiter in front of a single synchronous RAM, with optional zero-fill after reset.
module ram_arb2
  import veerwolf_pkg::*;
#(
  parameter int unsigned SIZE      = 65536,
  parameter int unsigned ZERO_INIT = 1,
  localparam int unsigned AW       = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_done,

  input  logic          r0_req,
  output logic          r0_gnt,
  input  logic [7:0]    r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [63:0]   r0_wdata,
  output logic          r0_rvalid,
  output logic [63:0]   r0_rdata,

  input  logic          r1_req,
  output logic          r1_gnt,
  input  logic [7:0]    r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [63:0]   r1_wdata,
  output logic          r1_rvalid,
  output logic [63:0]   r1_rdata,

  output logic [7:0]    ram_we,
  output logic [63:0]   ram_din,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  input  logic [63:0]   ram_dout
);

  localparam int unsigned CW = AW - $clog2(WordBytes);
  localparam arb_state_e ResetState = (ZERO_INIT != 0) ? StInit : StRun;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    gnt;

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (state_q == StRun),
    .req_i  ({r1_req, r0_req}),
    .gnt_o  (gnt)
  );

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign init_done = (state_q == StRun);
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_rdata  = ram_dout;
  assign r1_rdata  = ram_dout;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rvalid_d  = 2'b00;
    ram_we    = 8'h00;
    ram_din   = r0_wdata;
    ram_waddr = r0_addr;
    ram_raddr = r0_addr;
    unique case (state_q)
      StInit: begin
        ram_we    = 8'hFF;
        ram_din   = 64'h0;
        ram_waddr = {cnt_q, 3'b000};
        cnt_d     = cnt_q + CW'(1);
        if (&cnt_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (gnt[0]) begin
          if (|r0_we) begin
            ram_we    = r0_we;
            ram_din   = r0_wdata;
            ram_waddr = r0_addr;
          end else begin
            ram_raddr   = r0_addr;
            rvalid_d[0] = 1'b1;
          end
        end else if (gnt[1]) begin
          if (|r1_we) begin
            ram_we    = r1_we;
            ram_din   = r1_wdata;
            ram_waddr = r1_addr;
          end else begin
            ram_raddr   = r1_addr;
            rvalid_d[1] = 1'b1;
          end
        end
      end
      default: state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ResetState;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule
